// File: rtl/dds_freq_estimator_if.sv
// Sample stream into dds_freq_estimator and the frequency estimate coming back out.
// master = sample source / estimate consumer, slave = the estimator.
interface dds_freq_estimator_if #(
    parameter int PHASE_WIDTH  = 24,
    parameter int SAMPLE_WIDTH = 12
);
    logic [SAMPLE_WIDTH-1:0] sample_in;
    logic                    sample_valid;
    logic [PHASE_WIDTH-1:0]  fcw_est;
    logic                    fcw_valid;
    logic                    locked;
    logic                    overflow;

    modport master (
        output sample_in, sample_valid,
        input  fcw_est, fcw_valid, locked, overflow
    );

    modport slave (
        input  sample_in, sample_valid,
        output fcw_est, fcw_valid, locked, overflow
    );
endinterface

// File: rtl/dds_freq_estimator.sv
// Period-averaging frequency estimator producing a DDS FCW; FCW_EST_IIR_EN adds 1/4 smoothing.
// Latency: fcw_valid PHASE_WIDTH+AVG_LOG2+2 clk after the window-closing sample.
// No backpressure: every accepted sample is consumed; windows closing during a divide are dropped.
module dds_freq_estimator #(
    parameter int PHASE_WIDTH  = 24,
    parameter int SAMPLE_WIDTH = 12,
    parameter int PERIOD_WIDTH = 20,
    parameter int AVG_LOG2     = 2,
    parameter int HYST         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    dds_freq_estimator_if.slave  bus
);
    localparam int SUM_WIDTH  = PERIOD_WIDTH + AVG_LOG2;
    localparam int QUO_WIDTH  = PHASE_WIDTH + AVG_LOG2 + 1;
    localparam int DCNT_WIDTH = $clog2(QUO_WIDTH + 1);
    localparam int XCNT_WIDTH = AVG_LOG2 + 1;
    localparam int MID        = 2 ** (SAMPLE_WIDTH - 1);

    localparam logic [SAMPLE_WIDTH:0]   THR_HI    = (SAMPLE_WIDTH + 1)'(MID + HYST);
    localparam logic [SAMPLE_WIDTH:0]   THR_LO    = (SAMPLE_WIDTH + 1)'(MID - HYST);
    localparam logic [PERIOD_WIDTH-1:0] CNT_LAST  = PERIOD_WIDTH'(2 ** PERIOD_WIDTH - 2);
    localparam logic [XCNT_WIDTH-1:0]   XCNT_LAST = XCNT_WIDTH'(2 ** AVG_LOG2 - 1);
    localparam logic [DCNT_WIDTH-1:0]   DCNT_DONE = DCNT_WIDTH'(QUO_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_MEASURE
    } state_t;

    state_t                  state_q, state_d;
    logic                    level_q, level_d;
    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [SUM_WIDTH-1:0]    sum_q, sum_inc;
    logic [XCNT_WIDTH-1:0]   xcnt_q;
    logic                    overflow_q;

    logic                    div_busy_q;
    logic [DCNT_WIDTH-1:0]   div_cnt_q;
    logic [SUM_WIDTH-1:0]    rem_q, den_q, rem_sub;
    logic [SUM_WIDTH:0]      rem_shift;
    logic                    q_bit;
    logic [QUO_WIDTH-1:0]    quo_q;
    logic [PHASE_WIDTH-1:0]  q_sat, fcw_next, fcw_est_q;
    logic                    fcw_valid_q, locked_q;

    logic                    accept, crossing, timeout, win_close;
    logic                    div_start, div_fire, abort;
    logic [SAMPLE_WIDTH:0]   smp_ext;

    assign smp_ext = {1'b0, bus.sample_in};
    assign sum_inc = sum_q + SUM_WIDTH'(cnt_q) + SUM_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        level_d   = level_q;
        crossing  = 1'b0;
        timeout   = 1'b0;
        win_close = 1'b0;
        div_start = 1'b0;
        div_fire  = 1'b0;
        abort     = 1'b0;

        if (enable && state_q != ST_IDLE && bus.sample_valid) begin
            accept = 1'b1;
            if (smp_ext >= THR_HI)
                level_d = 1'b1;
            else if (smp_ext <= THR_LO)
                level_d = 1'b0;
            crossing = !level_q && level_d;
            // A crossing on the timeout sample restarts the period instead
            timeout  = !crossing && (cnt_q == CNT_LAST);
        end

        case (state_q)
            ST_IDLE:    state_d = ST_SEEK;
            ST_SEEK:    if (crossing) state_d = ST_MEASURE;
            ST_MEASURE: win_close = crossing && (xcnt_q == XCNT_LAST);
            default:    state_d = ST_IDLE;
        endcase

        if (timeout)
            state_d = ST_SEEK;
        if (!enable)
            state_d = ST_IDLE;

        abort     = !enable || timeout || (state_q == ST_IDLE);
        div_start = win_close && !div_busy_q && !abort;
        div_fire  = div_busy_q && (div_cnt_q == DCNT_DONE) && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            level_q    <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            xcnt_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (!enable || state_q == ST_IDLE) begin
                level_q    <= 1'b0;
                cnt_q      <= '0;
                sum_q      <= '0;
                xcnt_q     <= '0;
                overflow_q <= 1'b0;
            end else if (accept) begin
                level_q <= level_d;
                if (crossing) begin
                    cnt_q <= '0;
                    // The partial period seen in SEEK is never summed
                    if (state_q == ST_MEASURE) begin
                        sum_q  <= win_close ? '0 : sum_inc;
                        xcnt_q <= win_close ? '0 : xcnt_q + 1'b1;
                    end
                end else if (timeout) begin
                    cnt_q      <= '0;
                    sum_q      <= '0;
                    xcnt_q     <= '0;
                    overflow_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Restoring divide of 2^(QUO_WIDTH-1) by the window sum, MSB first
    assign rem_shift = {rem_q, (div_cnt_q == '0)};
    assign q_bit     = rem_shift >= {1'b0, den_q};
    assign rem_sub   = rem_shift[SUM_WIDTH-1:0] - den_q;
    assign q_sat     = (|quo_q[QUO_WIDTH-1:PHASE_WIDTH]) ? '1 : quo_q[PHASE_WIDTH-1:0];

`ifdef FCW_EST_IIR_EN
    logic signed [PHASE_WIDTH:0] iir_diff, iir_step;

    assign iir_diff = $signed({1'b0, q_sat}) - $signed({1'b0, fcw_est_q});
    assign iir_step = iir_diff >>> 2;
    // First estimate after SEEK loads directly; later ones move 1/4 of the way
    assign fcw_next = locked_q ? fcw_est_q + iir_step[PHASE_WIDTH-1:0] : q_sat;
`else
    assign fcw_next = q_sat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_busy_q  <= 1'b0;
            div_cnt_q   <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            fcw_est_q   <= '0;
            fcw_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            fcw_valid_q <= 1'b0;
            if (abort) begin
                div_busy_q <= 1'b0;
                locked_q   <= 1'b0;
            end else if (div_start) begin
                den_q      <= sum_inc;
                rem_q      <= '0;
                quo_q      <= '0;
                div_cnt_q  <= '0;
                div_busy_q <= 1'b1;
            end else if (div_fire) begin
                div_busy_q  <= 1'b0;
                fcw_est_q   <= fcw_next;
                fcw_valid_q <= 1'b1;
                locked_q    <= 1'b1;
            end else if (div_busy_q) begin
                rem_q     <= q_bit ? rem_sub : rem_shift[SUM_WIDTH-1:0];
                quo_q     <= {quo_q[QUO_WIDTH-2:0], q_bit};
                div_cnt_q <= div_cnt_q + 1'b1;
            end
        end
    end

    assign bus.fcw_est   = fcw_est_q;
    assign bus.fcw_valid = fcw_valid_q;
    assign bus.locked    = locked_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_dds_freq_estimator.sv
// Bench for dds_freq_estimator: cycle model of the estimator plus directed waveforms.
module tb_dds_freq_estimator;
    localparam int PW     = 24;
    localparam int SW     = 12;
    localparam int PERW   = 20;
    localparam int AL     = 2;
    localparam int HY     = 16;
    localparam int MID    = 1 << (SW - 1);
    localparam int LAT    = PW + AL + 2;
    localparam int NWIN   = 1 << AL;
    localparam int MAXCNT = (1 << PERW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic enable, enable2;
    always #5 clk = ~clk;

    dds_freq_estimator_if #(.PHASE_WIDTH(PW), .SAMPLE_WIDTH(SW)) bus  ();
    dds_freq_estimator_if #(.PHASE_WIDTH(PW), .SAMPLE_WIDTH(SW)) bus2 ();

    dds_freq_estimator #(.PHASE_WIDTH(PW), .SAMPLE_WIDTH(SW), .PERIOD_WIDTH(PERW),
                         .AVG_LOG2(AL), .HYST(HY))
        dut (.clk(clk), .rst(rst), .enable(enable), .bus(bus));

    dds_freq_estimator #(.PHASE_WIDTH(PW), .SAMPLE_WIDTH(SW), .PERIOD_WIDTH(8),
                         .AVG_LOG2(AL), .HYST(HY))
        dut_small (.clk(clk), .rst(rst), .enable(enable2), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: periods between rising Schmitt crossings, window sums, plain division
    int            m_phase = 0;   // 0 idle, 1 seek, 2 measure
    bit            m_level = 0;
    int            m_cnt = 0, m_sum = 0, m_n = 0;
    bit            m_pend = 0;
    int            m_start = 0, m_edge = 0;
    longint        m_q = 0;
    logic [PW-1:0] m_est = '0;
    bit            m_valid = 0, m_locked = 0, m_ovf = 0;
    bit            mb_busy, mb_fire, mb_nl, mb_cross;
    int            mb_s, mb_d;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_level = 0; m_cnt = 0; m_sum = 0; m_n = 0; m_pend = 0;
            m_est = '0; m_valid = 0; m_locked = 0; m_ovf = 0;
        end else begin
            m_edge++;
            mb_busy = m_pend;
            mb_fire = m_pend && (m_edge == m_start + LAT);
            m_valid = 0;
            if (!enable) begin
                m_phase = 0; m_level = 0; m_cnt = 0; m_sum = 0; m_n = 0;
                m_pend = 0; m_locked = 0; m_ovf = 0;
            end else if (m_phase == 0) begin
                m_phase = 1;
            end else begin
                if (bus.sample_valid) begin
                    mb_s = int'(bus.sample_in);
                    mb_nl = (mb_s >= MID + HY) ? 1'b1 : (mb_s <= MID - HY) ? 1'b0 : m_level;
                    mb_cross = !m_level && mb_nl;
                    m_level = mb_nl;
                    if (mb_cross) begin
                        if (m_phase == 1) begin
                            m_phase = 2;
                        end else begin
                            m_sum += m_cnt + 1;
                            m_n++;
                            if (m_n == NWIN) begin
                                if (!mb_busy) begin
                                    m_pend = 1;
                                    m_start = m_edge;
                                    m_q = (longint'(1) << (PW + AL)) / m_sum;
                                    if (m_q > (longint'(1) << PW) - 1) m_q = (longint'(1) << PW) - 1;
                                end
                                m_sum = 0;
                                m_n = 0;
                            end
                        end
                        m_cnt = 0;
                    end else if (m_cnt + 1 == MAXCNT) begin
                        m_ovf = 1; m_locked = 0; m_sum = 0; m_n = 0; m_cnt = 0;
                        m_phase = 1; m_pend = 0; mb_fire = 0;
                    end else begin
                        m_cnt++;
                    end
                end
                if (mb_fire) begin
                    m_pend = 0;
                    m_valid = 1;
`ifdef FCW_EST_IIR_EN
                    if (!m_locked) begin
                        m_est = PW'(m_q);
                    end else begin
                        mb_d = int'(m_q) - int'(m_est);
                        m_est = PW'(int'(m_est) + (mb_d >>> 2));
                    end
`else
                    m_est = PW'(m_q);
`endif
                    m_locked = 1;
                end
            end
        end
    end

    int            cyc = 0;
    int            n_valid = 0, n_valid2 = 0;
    int            first_cyc = -1, close_cyc = -2;
    logic [PW-1:0] first_est = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        check("fcw_valid", bus.fcw_valid, m_valid);
        check("fcw_est", bus.fcw_est, m_est);
        check("locked", bus.locked, m_locked);
        check("overflow", bus.overflow, m_ovf);
        if (bus.fcw_valid) begin
            if (n_valid == 0) begin
                first_cyc = cyc;
                first_est = bus.fcw_est;
            end
            n_valid++;
        end
        if (bus2.fcw_valid) n_valid2++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sq(input int j, input int p);
        return ((j % p) < p / 2) ? 'hC00 : 'h400;
    endfunction

    task automatic restart();
        enable = 1'b0;
        bus.sample_valid = 1'b0;
        tick();
        n_valid = 0;
        first_cyc = -1;
        close_cyc = -2;
        enable = 1'b1;
        tick();
    endtask

    // Square wave starting high at index first; gap inserts an invalid, level-flipping sample
    task automatic wave(input int p, input int first, input int n, input bit gap);
        for (int j = first; j < first + n; j++) begin
            bus.sample_in = SW'(sq(j, p));
            bus.sample_valid = 1'b1;
            tick();
            if (j == NWIN * p) close_cyc = cyc;
            if (gap) begin
                bus.sample_in = (sq(j, p) == 'hC00) ? SW'(0) : SW'('hFFF);
                bus.sample_valid = 1'b0;
                tick();
            end
        end
        bus.sample_valid = 1'b0;
    endtask

    initial begin
        int held;
        rst = 1'b1;
        enable = 1'b0;
        enable2 = 1'b0;
        bus.sample_in = '0;
        bus.sample_valid = 1'b0;
        bus2.sample_in = '0;
        bus2.sample_valid = 1'b0;
        repeat (3) tick();
        check("reset fcw_est", bus.fcw_est, 0);
        check("reset fcw_valid", bus.fcw_valid, 0);
        check("reset locked", bus.locked, 0);
        check("reset overflow", bus.overflow, 0);
        rst = 1'b0;
        tick();

        // Period 64: sum 256 -> 2^26/256
        restart();
        wave(64, 0, 320, 1'b0);
        check("p64 latency", first_cyc - close_cyc, LAT);
        check("p64 fcw_est", first_est, 'h040000);
        check("p64 locked", bus.locked, 1);

        // Period 100: 2^26/400 = 167772.16, floored
        restart();
        wave(100, 0, 450, 1'b0);
        check("p100 latency", first_cyc - close_cyc, LAT);
        check("p100 fcw_est", first_est, 167772);

        // Inside the hysteresis band: no crossings at all
        restart();
        for (int i = 0; i < 300; i++) begin
            bus.sample_in = SW'((i % 2) ? MID + 15 : MID - 15);
            bus.sample_valid = 1'b1;
            tick();
        end
        bus.sample_valid = 1'b0;
        check("hyst no valid", n_valid, 0);
        check("hyst locked", bus.locked, 0);

        // Valid every other clk; invalid samples would flip the level if counted
        restart();
        wave(64, 0, 300, 1'b1);
        check("gap latency", first_cyc - close_cyc, LAT);
        check("gap fcw_est", first_est, 'h040000);

        // Reset while the divider is busy
        restart();
        wave(64, 0, 266, 1'b0);
        rst = 1'b1;
        #1;
        check("rst fcw_est", bus.fcw_est, 0);
        check("rst locked", bus.locked, 0);
        check("rst fcw_valid", bus.fcw_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check("rst no valid", n_valid, 0);

        // Enable low while the second window divides: no pulse, estimate held
        restart();
        wave(64, 0, 522, 1'b0);
        held = n_valid;
        enable = 1'b0;
        repeat (40) tick();
        check("disable no valid", n_valid, held);
        check("disable fcw_est", bus.fcw_est, 'h040000);
        check("disable locked", bus.locked, 0);
        restart();
        wave(100, 0, 450, 1'b0);
        check("reenable fcw_est", first_est, 167772);
        check("reenable locked", bus.locked, 1);

        // 8-bit period counter: timeout on the 255th accepted sample
        enable2 = 1'b1;
        tick();
        for (int i = 1; i <= 255; i++) begin
            bus2.sample_in = SW'((i % 2) ? MID + 15 : MID - 15);
            bus2.sample_valid = 1'b1;
            tick();
            if (i == 254) check("small ovf before", bus2.overflow, 0);
        end
        check("small ovf after", bus2.overflow, 1);
        check("small locked", bus2.locked, 0);
        enable2 = 1'b0;
        bus2.sample_valid = 1'b0;
        tick();
        check("small ovf cleared", bus2.overflow, 0);

        // Crossing on the would-be timeout sample wins
        enable2 = 1'b1;
        tick();
        for (int i = 1; i <= 255; i++) begin
            bus2.sample_in = (i == 255) ? SW'('hC00) : SW'('h400);
            bus2.sample_valid = 1'b1;
            tick();
        end
        bus2.sample_valid = 1'b0;
        check("small cross wins", bus2.overflow, 0);
        check("small no valid", n_valid2, 0);
        enable2 = 1'b0;

`ifdef FCW_EST_IIR_EN
        restart();
        wave(64, 0, 640, 1'b0);
        wave(32, 640, 800, 1'b0);
        repeat (40) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
